// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions.
// FSM state encoding used by the sequential divider and multiplier.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports: pr/q/divisor in; pr_next/q_next out.
module div_step
  import arith_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N:0]   pr,
  input  logic [N-1:0] q,
  input  logic [N-1:0] divisor,
  output logic [N:0]   pr_next,
  output logic [N-1:0] q_next
);

  logic [N:0] sh;
  logic [N:0] t;
  logic       unused_pr_msb;

  // pr stays below the divisor, so its top bit never feeds the shift.
  assign unused_pr_msb = pr[N];

  assign sh = {pr[N-1:0], q[N-1]};
  assign t  = sh - {1'b0, divisor};

  always_comb begin
    pr_next = sh;
    q_next  = {q[N-2:0], 1'b0};
    if (!t[N]) begin
      pr_next = t;
      q_next  = {q[N-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Ports: clk, reset(n), start, a_in, b_in -> quo, rem, busy, finish, div_zero.
module seq_divider
  import arith_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  output logic [N-1:0] quo,
  output logic [N-1:0] rem,
  output logic         busy,
  output logic         finish,
  output logic         div_zero
);

  localparam int CW = $clog2(N + 1);

  state_t       state;
  logic [CW-1:0] count;
  logic [N:0]   pr;
  logic [N-1:0] q;
  logic [N-1:0] dvs;
  logic [N:0]   pr_n;
  logic [N-1:0] q_n;

  div_step #(.N(N)) u_step (
    .pr      (pr),
    .q       (q),
    .divisor (dvs),
    .pr_next (pr_n),
    .q_next  (q_n)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      pr       <= '0;
      q        <= '0;
      dvs      <= '0;
      quo      <= '0;
      rem      <= '0;
      busy     <= 1'b0;
      finish   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            dvs    <= b_in;
            quo    <= '0;
            rem    <= '0;
            finish <= 1'b0;
            if (b_in == '0) begin
              quo      <= '1;
              rem      <= a_in;
              div_zero <= 1'b1;
              finish   <= 1'b1;
              state    <= DONE;
            end else begin
              div_zero <= 1'b0;
              busy     <= 1'b1;
              count    <= CW'(N);
              pr       <= '0;
              q        <= a_in;
              state    <= CALC;
            end
          end
        end
        CALC: begin
          pr    <= pr_n;
          q     <= q_n;
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            quo    <= q_n;
            rem    <= pr_n[N-1:0];
            busy   <= 1'b0;
            finish <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          if (!start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider (N=8).
// Immediate-assertion checks with a pass/fail summary.
module tb_seq_divider;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] a_in = '0;
  logic [N-1:0] b_in = '0;
  logic [N-1:0] quo;
  logic [N-1:0] rem;
  logic         busy;
  logic         finish;
  logic         div_zero;

  int tests = 0;
  int fails = 0;

  seq_divider #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .quo      (quo),
    .rem      (rem),
    .busy     (busy),
    .finish   (finish),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for finish, counting edges after the launch edge.
  task automatic wait_fin(output int n);
    n = 0;
    while (finish !== 1'b1 && n < 40) begin
      if (busy !== 1'b1) begin
        check("busy_in_calc", 32'(busy), 32'd1);
      end
      tick();
      n++;
    end
  endtask

  task automatic run(input string tag,
                     input logic [N-1:0] a,
                     input logic [N-1:0] b,
                     input logic [N-1:0] eq,
                     input logic [N-1:0] er,
                     input logic ez,
                     input int elat);
    int n;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy0"}, 32'(busy), 32'(b != 0));
    wait_fin(n);
    check({tag, "_lat"}, 32'(n), 32'(elat));
    check({tag, "_quo"}, 32'(quo), 32'(eq));
    check({tag, "_rem"}, 32'(rem), 32'(er));
    check({tag, "_dz"}, 32'(div_zero), 32'(ez));
    check({tag, "_busyfin"}, 32'(busy), 32'd0);
    tick();
  endtask

  initial begin
    int n;
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    // Reset state
    #2;
    check("rst_quo", 32'(quo), 32'd0);
    check("rst_rem", 32'(rem), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fin", 32'(finish), 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("idle_fin", 32'(finish), 32'd0);

    // 1. Basic division
    run("d200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 8);

    // 2. Boundary quotients
    run("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 8);
    run("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
    run("d0_13", 8'd0, 8'd13, 8'd0, 8'd0, 1'b0, 8);
    run("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 8);

    // 3. Divide by zero
    run("d37_0", 8'd37, 8'd0, 8'd255, 8'd37, 1'b1, 0);

    // 4. Reset mid-calculation
    a_in  = 8'd200;
    b_in  = 8'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_quo", 32'(quo), 32'd0);
    check("abort_rem", 32'(rem), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_fin", 32'(finish), 32'd0);
    check("abort_dz", 32'(div_zero), 32'd0);
    tick();
    reset = 1'b1;
    repeat (10) tick();
    check("abort_idle_fin", 32'(finish), 32'd0);
    check("abort_idle_busy", 32'(busy), 32'd0);
    run("d100_3", 8'd100, 8'd3, 8'd33, 8'd1, 1'b0, 8);

    // 5. start held through DONE
    a_in  = 8'd50;
    b_in  = 8'd6;
    start = 1'b1;
    tick();
    wait_fin(n);
    check("hold_lat", 32'(n), 32'd8);
    repeat (5) tick();
    check("hold_fin", 32'(finish), 32'd1);
    check("hold_busy", 32'(busy), 32'd0);
    check("hold_quo", 32'(quo), 32'd8);
    check("hold_rem", 32'(rem), 32'd2);
    start = 1'b0;
    tick();
    run("d9_4", 8'd9, 8'd4, 8'd2, 8'd1, 1'b0, 8);

    // 6. Operands changing during CALC
    a_in  = 8'd200;
    b_in  = 8'd7;
    start = 1'b1;
    tick();
    n = 0;
    while (finish !== 1'b1 && n < 40) begin
      a_in  = 8'($urandom);
      b_in  = 8'($urandom);
      start = 1'($urandom);
      tick();
      n++;
    end
    start = 1'b0;
    check("chg_lat", 32'(n), 32'd8);
    check("chg_quo", 32'(quo), 32'd28);
    check("chg_rem", 32'(rem), 32'd4);
    tick();

    // Random sweep against / and %, plus the invariant
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom_range(1, 255));
      run("rnd", ra, rb, ra / rb, ra % rb, 1'b0, 8);
      check("rnd_inv", 32'(quo) * 32'(rb) + 32'(rem), 32'(ra));
      check("rnd_lt", 32'(rem < rb), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
